seq_mult: RTL and testbench

Parametrised iterative shift-add multiplier that replaces the fixed-width combinational array multipliers in the arithmetic library. It takes WIDTH-bit operands through a valid/ready input handshake and computes one multiplier bit per clock. It supports signed (two's complement) and unsigned modes, selected per operation. It returns a 2*WIDTH-bit product through a valid/ready output handshake with backpressure.

---
 rtl/seq_mult.sv | 124 ++++++++++++
 tb/tb_seq_mult.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier, one multiplier bit per clock, signed/unsigned per operation.
// Optional early termination when the remaining multiplier is zero: define MULT_EARLY_TERM_EN.
module seq_mult #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 is_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid never depends on ready, and in_ready/out_valid depend on state only.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [2*WIDTH-1:0]   acc_sum;
  logic [WIDTH-1:0]     mplier_shift;
  logic                 last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      product_q <= product_d;
    end
  end

  // Magnitude of the most-negative value wraps to 2^(WIDTH-1), still correct unsigned.
  always_comb begin
    mag_a        = (is_signed && a[WIDTH-1]) ? -a : a;
    mag_b        = (is_signed && b[WIDTH-1]) ? -b : b;
    acc_sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
    mplier_shift = mplier_q >> 1;
`ifdef MULT_EARLY_TERM_EN
    last_step    = (cnt_q == LAST_BIT) || (mplier_shift == '0);
`else
    last_step    = (cnt_q == LAST_BIT);
`endif
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid)  state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    product_d = product_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d  = {{WIDTH{1'b0}}, mag_a};
          mplier_d = mag_b;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        end
      end
      S_RUN: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_shift;
        cnt_d    = cnt_q + 1'b1;
        if (last_step) product_d = neg_q ? -acc_sum : acc_sum;
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
    product   = product_q;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_seq_mult.sv
// Directed-vector bench for seq_mult (WIDTH=16): product table, latency, backpressure, mid-op reset.
module tb_seq_mult;

  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           is_signed;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] product;
  logic           busy;
  logic [1:0]     dbg_state;

  int total;
  int bad;

  typedef struct {
    logic [W-1:0]   va;
    logic [W-1:0]   vb;
    logic           vs;
    logic [2*W-1:0] exp_p;
  } vec_t;

  vec_t vecs[13];

  seq_mult #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .is_signed (is_signed),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] tb_b, input logic ts);
`ifdef MULT_EARLY_TERM_EN
    logic [W-1:0] m;
    int p;
    m = (ts && tb_b[W-1]) ? -tb_b : tb_b;
    p = 0;
    for (int i = 0; i < W; i++) if (m[i]) p = i;
    return p + 1;
`else
    return W;
`endif
  endfunction

  // Called at #1 after an edge with the DUT idle; returns after out_valid is seen.
  task automatic start_and_wait(input logic [W-1:0] ta, input logic [W-1:0] tb_b,
                                input logic ts, output int lat);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    a = ta; b = tb_b; is_signed = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); is_signed = 1'($urandom_range(0, 1));
    check("in_ready_after_accept", 64'(in_ready), 64'd0);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!out_valid && lat < 100);
  endtask

  task automatic finish_handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("in_ready_after_handshake", 64'(in_ready), 64'd1);
    check("out_valid_after_handshake", 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    logic [2*W-1:0] held;

    total = 0; bad = 0;
    in_valid = 1'b0; a = '0; b = '0; is_signed = 1'b0; out_ready = 1'b0;

    vecs[0]  = '{16'h0003, 16'h0005, 1'b0, 32'h0000000F};
    vecs[1]  = '{16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001};
    vecs[2]  = '{16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1};
    vecs[3]  = '{16'h8000, 16'h8000, 1'b1, 32'h40000000};
    vecs[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001};
    vecs[5]  = '{16'h1234, 16'h0000, 1'b0, 32'h00000000};
    vecs[6]  = '{16'h1234, 16'h8000, 1'b0, 32'h091A0000};
    vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 32'h40000000};
    vecs[8]  = '{16'h0007, 16'h0009, 1'b0, 32'h0000003F};
    vecs[9]  = '{16'hFFFF, 16'h0001, 1'b1, 32'hFFFFFFFF};
    vecs[10] = '{16'h8000, 16'h0001, 1'b1, 32'hFFFF8000};
    vecs[11] = '{16'h0012, 16'hFFFE, 1'b1, 32'hFFFFFFDC};
    vecs[12] = '{16'h8000, 16'hFFFF, 1'b1, 32'h00008000};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_product", 64'(product), 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++) begin
      start_and_wait(vecs[i].va, vecs[i].vb, vecs[i].vs, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].vb, vecs[i].vs)));
      check($sformatf("vec%0d_product", i), 64'(product), 64'(vecs[i].exp_p));
      check($sformatf("vec%0d_busy", i), 64'(busy), 64'd1);
      finish_handshake();
    end

    // Backpressure with an ignored in_valid pulse while DONE.
    start_and_wait(16'h0003, 16'h0005, 1'b0, lat);
    held = 32'h0000000F;
    for (int c = 0; c < 10; c++) begin
      if (c == 3) begin
        a = 16'h0009; b = 16'h0009; is_signed = 1'b0; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
      check("bp_product_held", 64'(product), 64'(held));
      check("bp_in_ready_low", 64'(in_ready), 64'd0);
      check("bp_out_valid_high", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    finish_handshake();
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_pulse_not_accepted", 64'(busy), 64'd0);
    end

    // Reset five cycles into an operation.
    start_and_wait(16'h0007, 16'h0009, 1'b0, lat);
    finish_handshake();
    a = 16'h1234; b = 16'h5678; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_product", 64'(product), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    check("midreset_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_and_wait(16'h0007, 16'h0009, 1'b0, lat);
    check("after_reset_latency", 64'(lat), 64'(exp_lat(16'h0009, 1'b0)));
    check("after_reset_product", 64'(product), 64'd63);
    finish_handshake();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
